// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and picks the next PC
// from the sequential, jump (ID) and branch (EX) sources. A redirect flushes
// IF/ID with a bubble. A load-use stall freezes both the PC and IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] inst_id,
  output logic [31:0] pc4_id,
  output logic        valid_id
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] seq;
  logic [31:0] jtarget;
  logic [31:0] btarget;

  // Candidate PCs. The jump target is built from the PC+4 of the jump
  // instruction, which is the word currently held in IF/ID.
  assign seq     = pc_q + 32'd4;
  assign jtarget = {pc4_q[31:28], jump_index, 2'b00};
  assign btarget = {branch_target[31:2], 2'b00};

  // Next-state selection: the branch is the older instruction, so it beats the
  // jump, and any redirect beats a stall.
  always_comb begin
    // NOTE: every _d gets a default first, so no path through this block
    // leaves a signal unassigned and no latch is inferred.
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (branch_taken) begin
      pc_d    = btarget;
      inst_d  = NOP_INST;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (jump) begin
      pc_d    = jtarget;
      inst_d  = NOP_INST;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = seq;
      inst_d  = imem_data;
      pc4_d   = seq;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers. A synchronous reset wins over every other input.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst_id   = inst_q;
  assign pc4_id    = pc4_q;
  assign valid_id  = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory answers addr ^ 32'hA5A5_0000.
// A second instance starts at 32'hFFFF_FFFC to exercise PC wrap-around.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [31:0] imem_addr, imem_data, pc, inst_id, pc4_id;
  logic        valid_id;

  logic [31:0] w_imem_addr, w_imem_data, w_pc, w_inst_id, w_pc4_id;
  logic        w_valid_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data   = imem_addr ^ 32'hA5A5_0000;
  assign w_imem_data = w_imem_addr ^ 32'hA5A5_0000;

  fetch_stage u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .jump(jump), .jump_index(jump_index),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .inst_id(inst_id), .pc4_id(pc4_id), .valid_id(valid_id)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0000)) u_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .stall(stall), .jump(jump), .jump_index(jump_index),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(w_pc), .inst_id(w_inst_id), .pc4_id(w_pc4_id), .valid_id(w_valid_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                          input logic [31:0] e_pc4, input logic e_valid);
    check({tag, ".pc"},    pc,      e_pc);
    check({tag, ".inst"},  inst_id, e_inst);
    check({tag, ".pc4"},   pc4_id,  e_pc4);
    check({tag, ".valid"}, {31'd0, valid_id}, {31'd0, e_valid});
    check({tag, ".imem"},  imem_addr, e_pc);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_index = '0;
    branch_taken = 1'b0; branch_target = '0;
    step(); step();
    check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("wrap_reset.pc", w_pc, 32'hFFFF_FFFC);

    // Free-running fetch.
    reset = 1'b0;
    step();
    check_if("run1", 32'h4, 32'hA5A5_0000, 32'h4, 1'b1);
    check("wrap.pc",    w_pc,      32'h0);
    check("wrap.pc4",   w_pc4_id,  32'h0);
    check("wrap.inst",  w_inst_id, 32'h5A5A_FFFC);
    check("wrap.valid", {31'd0, w_valid_id}, 32'd1);
    step();
    check_if("run2", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1);
    step();
    check_if("run3", 32'hC, 32'hA5A5_0008, 32'hC, 1'b1);
    step();
    check_if("run4", 32'h10, 32'hA5A5_000C, 32'h10, 1'b1);

    // Three-cycle stall at pc = 0x10, then release.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_if("stall", 32'h10, 32'hA5A5_000C, 32'h10, 1'b1);
    end
    stall = 1'b0;
    step();
    check_if("release", 32'h14, 32'hA5A5_0010, 32'h14, 1'b1);

    // Branch to 0x4000_0004 so that pc4_id becomes 0x4000_0008.
    branch_taken = 1'b1; branch_target = 32'h4000_0004;
    step();
    check_if("br1", 32'h4000_0004, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    step();
    check_if("br1_next", 32'h4000_0008, 32'hE5A5_0004, 32'h4000_0008, 1'b1);

    // Jump with pc4_id = 0x4000_0008, index 0x40, and stall also raised.
    jump = 1'b1; jump_index = 26'h0000040; stall = 1'b1;
    step();
    check_if("jump", 32'h4000_0100, 32'h0, 32'h0, 1'b0);
    jump = 1'b0; stall = 1'b0;
    step();
    check_if("jump_next", 32'h4000_0104, 32'hE5A5_0100, 32'h4000_0104, 1'b1);

    // Branch together with jump and stall: branch wins, low bits cleared.
    branch_taken = 1'b1; branch_target = 32'h0000_0203;
    jump = 1'b1; jump_index = 26'h3FF_FFFF; stall = 1'b1;
    step();
    check_if("br_prio", 32'h200, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    step();
    check_if("br_prio_next", 32'h204, 32'hA5A5_0200, 32'h204, 1'b1);

    // Reach pc = 0x40 with a valid IF/ID, then reset during a stall.
    branch_taken = 1'b1; branch_target = 32'h0000_003C;
    step();
    branch_taken = 1'b0;
    step();
    check_if("pre_rst", 32'h40, 32'hA5A5_003C, 32'h40, 1'b1);
    stall = 1'b1; reset = 1'b1;
    step();
    check_if("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0; stall = 1'b0;
    step();
    check_if("post_rst", 32'h4, 32'hA5A5_0000, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
